mult_sched: RTL and testbench
=============================

# mult_sched

Two-requester scheduler that shares one multi-cycle partial-product multiplier between the integer MUL path and the FPU mantissa path. Accepts operand pairs on two valid/ready ports and arbitrates round-robin. Launches the shared multiplier, counts its fixed MULT_CYCLES latency, captures the 2×DATA_WIDTH product, and returns it with a requester ID on a single valid/ready response port. Sits between the core/FPU issue logic and the multiplier datapath; the multiplier itself holds no handshake state.

## Interface
- DATA_WIDTH, 32, operand width; product is 2*DATA_WIDTH.
- MULT_CYCLES, 4, multiplier latency in cycles from start to product valid; legal range ≥1.
- clkIn  in  1  clock; all state updates on rising edge.
- rstIn  in  1  reset, asynchronous, active-high.
- req0ValidIn  in  1  requester 0 (integer MUL) has operands.
- req0ReadyOut  out  1  requester 0 may transfer.
- req0AIn, req0BIn  in  DATA_WIDTH each  requester 0 operands, unsigned.
- req1ValidIn, req1ReadyOut, req1AIn, req1BIn: same for requester 1 (FPU mantissa).
- multStartOut  out  1  single-cycle launch pulse to the multiplier.
- multAOut, multBOut  out  DATA_WIDTH each  registered operands; held stable from launch until capture.
- multProdIn  in  2*DATA_WIDTH  multiplier product; valid exactly MULT_CYCLES cycles after the multStartOut cycle.
- respValidOut  out  1  result available.
- respReadyIn  in  1  consumer accepts result.
- respIdOut  out  1  requester ID of the result (0 or 1).
- respProdOut  out  2*DATA_WIDTH  captured product.
- busyOut  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, LAUNCH, WAIT, RESP. Reset state is IDLE.
- IDLE: req0ReadyOut/req1ReadyOut are driven high only in IDLE, each gated by the arbitration result; only one is ever high in a cycle. On a transfer (valid&ready): latch operands into multAOut/multBOut, latch ID, update lastGrant, go to LAUNCH.
- Arbitration: if only one valid, grant it. If both valid, grant the one ≠ lastGrant. lastGrant resets to 1, so requester 0 wins the first contention.
- LAUNCH: multStartOut=1 for this cycle only. Load the counter with MULT_CYCLES-1, go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle where the counter is 0, sample multProdIn into respProdOut and go to RESP. Counter width is $clog2(MULT_CYCLES+1). For MULT_CYCLES=1, WAIT lasts exactly one cycle.
- RESP: respValidOut=1, with respProdOut/respIdOut stable. On respValidOut&respReadyIn, go to IDLE. No new request is accepted in the same cycle.
- Products are not truncated or sign-handled; respProdOut equals multProdIn exactly.
- Reset in any state: return immediately to IDLE and drop the in-flight operation. No response is ever issued for it.
- Reset values:
  - all ready/valid/start outputs 0;
  - busyOut 0;
  - multAOut, multBOut, respProdOut 0;
  - respIdOut 0;
  - counter 0;
  - lastGrant 1.

## Timing
- Transfer in cycle T:
  - multStartOut high in T+1;
  - capture at the end of T+1+MULT_CYCLES;
  - respValidOut first high in T+2+MULT_CYCLES (T+6 with the defaults).
- Minimum issue interval with respReadyIn held high: MULT_CYCLES+3 cycles (7 with the defaults).
- Ready outputs are combinational from the state, lastGrant and the valid inputs. Valid inputs must not depend on ready.
- A requester holding valid while not granted must keep its operands stable. The scheduler never drops an un-transferred request.
- respValidOut, once high, stays high with stable data until accepted, regardless of new requests.

## Test plan
- Defaults. Single request on req0, A=3, B=5, at cycle T -> multStartOut pulse at T+1; respValidOut at T+6 with respProdOut=15 and respIdOut=0; busyOut high T+1..T+6.
- Both requesters valid after reset: req0 A=2 B=7, req1 A=4 B=9 -> req0 served first (14, id 0), then req1 (36, id 1). Next contention grants req0 again (alternation).
- Both requesters held valid for 6 operations -> grant IDs strictly alternate 0,1,0,1,0,1; issue interval 7 cycles.
- respReadyIn low for 10 cycles during RESP -> respValidOut, respProdOut, respIdOut stable; both ready outputs low; no multStartOut; the single respReadyIn pulse completes the operation.
- rstIn asserted during WAIT -> all outputs reach reset values without waiting for a clock edge. After release, no response appears for the dropped op, and a new req1 request is accepted and completes normally.
- A=B=0xFFFFFFFF, with MULT_CYCLES=1 and MULT_CYCLES=4 builds -> respProdOut=0xFFFFFFFE00000001. Latency is 3 and 6 cycles respectively.

Source files
------------

// File: rtl/mult_sched.sv
// mult_sched: shares one fixed-latency multiplier between two requesters
// (0 = integer MUL, 1 = FPU mantissa) using round-robin arbitration.
// Ports:
//   clkIn, rstIn                   clock, async active-high reset
//   req{0,1}ValidIn/ReadyOut/A/B   operand ports (valid/ready)
//   multStartOut, multAOut/BOut    launch pulse and held operands
//   multProdIn                     product, valid MULT_CYCLES after launch
//   respValidOut/ReadyIn/Id/Prod   result port (valid/ready)
//   busyOut                        high whenever not idle
module mult_sched #(
  parameter int DATA_WIDTH  = 32,
  parameter int MULT_CYCLES = 4
) (
  input  logic                    clkIn,
  input  logic                    rstIn,
  input  logic                    req0ValidIn,
  output logic                    req0ReadyOut,
  input  logic [DATA_WIDTH-1:0]   req0AIn,
  input  logic [DATA_WIDTH-1:0]   req0BIn,
  input  logic                    req1ValidIn,
  output logic                    req1ReadyOut,
  input  logic [DATA_WIDTH-1:0]   req1AIn,
  input  logic [DATA_WIDTH-1:0]   req1BIn,
  output logic                    multStartOut,
  output logic [DATA_WIDTH-1:0]   multAOut,
  output logic [DATA_WIDTH-1:0]   multBOut,
  input  logic [2*DATA_WIDTH-1:0] multProdIn,
  output logic                    respValidOut,
  input  logic                    respReadyIn,
  output logic                    respIdOut,
  output logic [2*DATA_WIDTH-1:0] respProdOut,
  output logic                    busyOut
);

  localparam int CNT_W = $clog2(MULT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;
  logic             grant0, grant1;
  logic             take0, take1;
  logic             capture;

  // Under contention the requester that did not win last time is granted.
  // Ready is masked during reset so no transfer is advertised then.
  always_comb begin
    grant0       = req0ValidIn & (~req1ValidIn | last_grant);
    grant1       = req1ValidIn & (~req0ValidIn | ~last_grant);
    req0ReadyOut = (state == IDLE) & ~rstIn & grant0;
    req1ReadyOut = (state == IDLE) & ~rstIn & grant1;
    take0        = req0ValidIn & req0ReadyOut;
    take1        = req1ValidIn & req1ReadyOut;
    capture      = (state == WAIT) && (cnt == '0);
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    multStartOut = 1'b0;
    respValidOut = 1'b0;
    busyOut      = (state != IDLE);
    case (state)
      IDLE: begin
        if (take0 | take1) state_next = LAUNCH;
      end
      LAUNCH: begin
        multStartOut = 1'b1;
        state_next   = WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_next = RESP;
      end
      RESP: begin
        respValidOut = 1'b1;
        if (respReadyIn) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      multAOut    <= '0;
      multBOut    <= '0;
      respIdOut   <= 1'b0;
      last_grant  <= 1'b1;
      cnt         <= '0;
      respProdOut <= '0;
    end else begin
      if (take0) begin
        multAOut   <= req0AIn;
        multBOut   <= req0BIn;
        respIdOut  <= 1'b0;
        last_grant <= 1'b0;
      end else if (take1) begin
        multAOut   <= req1AIn;
        multBOut   <= req1BIn;
        respIdOut  <= 1'b1;
        last_grant <= 1'b1;
      end

      // Loaded with MULT_CYCLES-1 so the capture lands on the WAIT cycle in
      // which the product is valid; MULT_CYCLES=1 gives a single WAIT cycle.
      if (state == LAUNCH) begin
        cnt <= CNT_W'(MULT_CYCLES - 1);
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end

      if (capture) begin
        respProdOut <= multProdIn;
      end
    end
  end

endmodule

// File: tb/tb_mult_sched.sv
// tb_mult_sched: directed bench for mult_sched with a delay-line model of
// the shared multiplier (MULT_CYCLES=4 main instance, MULT_CYCLES=1 second).
module tb_mult_sched;

  localparam int MC = 4;
  localparam logic [63:0] GARBAGE = 64'hDEAD_BEEF_DEAD_BEEF;

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0, rr = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        r0, r1, start, rv, rid, busy;
  logic [31:0] ma, mb;
  logic [63:0] prod, rprod;

  logic        d1_v0 = 1'b0, d1_rr = 1'b0;
  logic [31:0] d1_a0 = '0, d1_b0 = '0, d1_zero = '0;
  logic        d1_r0, d1_r1, d1_start, d1_rv, d1_rid, d1_busy;
  logic [31:0] d1_ma, d1_mb;
  logic [63:0] d1_prod, d1_rprod;

  int n_cmp = 0;
  int n_fail = 0;

  mult_sched #(.DATA_WIDTH(32), .MULT_CYCLES(MC)) u_dut (
    .clkIn(clk), .rstIn(rst),
    .req0ValidIn(v0), .req0ReadyOut(r0), .req0AIn(a0), .req0BIn(b0),
    .req1ValidIn(v1), .req1ReadyOut(r1), .req1AIn(a1), .req1BIn(b1),
    .multStartOut(start), .multAOut(ma), .multBOut(mb), .multProdIn(prod),
    .respValidOut(rv), .respReadyIn(rr), .respIdOut(rid), .respProdOut(rprod),
    .busyOut(busy)
  );

  mult_sched #(.DATA_WIDTH(32), .MULT_CYCLES(1)) u_dut1 (
    .clkIn(clk), .rstIn(rst),
    .req0ValidIn(d1_v0), .req0ReadyOut(d1_r0), .req0AIn(d1_a0), .req0BIn(d1_b0),
    .req1ValidIn(1'b0), .req1ReadyOut(d1_r1), .req1AIn(d1_zero), .req1BIn(d1_zero),
    .multStartOut(d1_start), .multAOut(d1_ma), .multBOut(d1_mb), .multProdIn(d1_prod),
    .respValidOut(d1_rv), .respReadyIn(d1_rr), .respIdOut(d1_rid), .respProdOut(d1_rprod),
    .busyOut(d1_busy)
  );

  initial forever #5 clk = ~clk;

  // Multiplier model: product presented only in the cycle MC after the start
  // cycle, garbage otherwise, so a mistimed capture is visible.
  logic [MC-1:0] pv = '0;
  logic [63:0]   pp [MC];
  always @(posedge clk) begin
    pv[0] <= start;
    pp[0] <= 64'(ma) * 64'(mb);
    for (int i = 1; i < MC; i++) begin
      pv[i] <= pv[i-1];
      pp[i] <= pp[i-1];
    end
  end
  assign prod = pv[MC-1] ? pp[MC-1] : GARBAGE;

  logic        pv1 = 1'b0;
  logic [63:0] pp1 = '0;
  always @(posedge clk) begin
    pv1 <= d1_start;
    pp1 <= 64'(d1_ma) * 64'(d1_mb);
  end
  assign d1_prod = pv1 ? pp1 : GARBAGE;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_op(input vec_t v);
    int lat, bad_busy, extra_start;
    bit got;
    @(negedge clk);
    rr = 1'b1;
    if (v.id) begin v1 = 1'b1; a1 = v.a; b1 = v.b; end
    else      begin v0 = 1'b1; a0 = v.a; b0 = v.b; end
    #1;
    check("op_ready0", 64'(r0), 64'(!v.id));
    check("op_ready1", 64'(r1), 64'(v.id));
    @(negedge clk);
    v0 = 1'b0;
    v1 = 1'b0;
    check("op_start", 64'(start), 64'd1);
    check("op_busy_launch", 64'(busy), 64'd1);
    check("op_mult_a", 64'(ma), 64'(v.a));
    check("op_mult_b", 64'(mb), 64'(v.b));
    lat = 1; got = 0; bad_busy = 0; extra_start = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (start) extra_start++;
      if (!busy) bad_busy++;
      if (rv) got = 1;
    end
    check("op_latency", 64'(lat), 64'(MC + 2));
    check("op_prod", rprod, v.prod);
    check("op_id", 64'(rid), 64'(v.id));
    check("op_single_start", 64'(extra_start), 64'd0);
    check("op_busy_hold", 64'(bad_busy), 64'd0);
    @(negedge clk);
    check("op_idle", {62'd0, rv, busy}, 64'd0);
  endtask

  vec_t tbl [6];

  initial begin
    int t, ns, nr, lat;
    int st [8];
    logic        ids [6];
    logic [63:0] prods [6];
    int bad_v, bad_d, bad_r, bad_s, quiet;
    bit got;

    tbl[0] = '{1'b0, 32'd3,          32'd5,          64'd15};
    tbl[1] = '{1'b1, 32'h0000_1234,  32'h0000_0010,  64'h0000_0000_0001_2340};
    tbl[2] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
    tbl[3] = '{1'b1, 32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000};
    tbl[4] = '{1'b0, 32'h0000_ABCD,  32'd0,          64'd0};
    tbl[5] = '{1'b1, 32'd12345,      32'd678,        64'd8369910};

    // Reset values, checked before any clock edge; valid held to prove ready is masked.
    v0 = 1'b1;
    #1 rst = 1'b1;
    #2;
    check("rst_ready0", 64'(r0), 64'd0);
    check("rst_ready1", 64'(r1), 64'd0);
    check("rst_start", 64'(start), 64'd0);
    check("rst_valid", 64'(rv), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mult_ab", {ma, mb}, 64'd0);
    check("rst_prod", rprod, 64'd0);
    check("rst_id", 64'(rid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    v0 = 1'b0;

    for (int i = 0; i < 6; i++) run_op(tbl[i]);

    // Contention after reset: strict alternation starting with requester 0.
    do_reset();
    @(negedge clk);
    a0 = 32'd2; b0 = 32'd7; a1 = 32'd4; b1 = 32'd9;
    v0 = 1'b1; v1 = 1'b1; rr = 1'b1;
    #1;
    check("arb_first_r0", 64'(r0), 64'd1);
    check("arb_first_r1", 64'(r1), 64'd0);
    t = 0; ns = 0; nr = 0;
    for (int i = 0; i < 6; i++) begin ids[i] = 1'bx; prods[i] = '1; end
    for (int k = 0; k < 100 && nr < 6; k++) begin
      @(negedge clk);
      t++;
      if (start) begin
        if (ns < 8) st[ns] = t;
        ns++;
      end
      if (rv) begin
        ids[nr] = rid;
        prods[nr] = rprod;
        nr++;
        if (nr == 6) begin v0 = 1'b0; v1 = 1'b0; end
      end
    end
    check("alt_resp_count", 64'(nr), 64'd6);
    check("alt_start_count", 64'(ns), 64'd6);
    for (int i = 0; i < 6; i++) begin
      check("alt_id", 64'(ids[i]), 64'(i % 2));
      check("alt_prod", prods[i], (i % 2) ? 64'd36 : 64'd14);
    end
    for (int i = 1; i < 6 && i < ns; i++) check("alt_interval", 64'(st[i] - st[i-1]), 64'(MC + 3));
    @(negedge clk);
    check("alt_idle", 64'(busy), 64'd0);

    // Response stall: respReadyIn low for 10 cycles with both requesters pushing.
    do_reset();
    @(negedge clk);
    v1 = 1'b1; a1 = 32'd6; b1 = 32'd7; rr = 1'b0;
    @(negedge clk);
    v1 = 1'b0;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (rv) got = 1;
    end
    check("stall_reached", 64'(got), 64'd1);
    a0 = 32'd1; b0 = 32'd1; a1 = 32'd1; b1 = 32'd1;
    v0 = 1'b1; v1 = 1'b1;
    bad_v = 0; bad_d = 0; bad_r = 0; bad_s = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (!rv) bad_v++;
      if (rprod !== 64'd42 || rid !== 1'b1) bad_d++;
      if (r0 | r1) bad_r++;
      if (start) bad_s++;
      @(negedge clk);
    end
    check("stall_valid", 64'(bad_v), 64'd0);
    check("stall_data", 64'(bad_d), 64'd0);
    check("stall_ready", 64'(bad_r), 64'd0);
    check("stall_start", 64'(bad_s), 64'd0);
    v0 = 1'b0; v1 = 1'b0; rr = 1'b1;
    #1;
    check("stall_still_valid", 64'(rv), 64'd1);
    @(negedge clk);
    rr = 1'b0;
    check("stall_release", {62'd0, rv, busy}, 64'd0);

    // Reset during WAIT on a req1 op; respProd/respId still hold the stalled op.
    @(negedge clk);
    v1 = 1'b1; a1 = 32'd10; b1 = 32'd10; rr = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    @(negedge clk);
    check("rstw_busy_before", 64'(busy), 64'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstw_busy", 64'(busy), 64'd0);
    check("rstw_valid_start", {62'd0, rv, start}, 64'd0);
    check("rstw_mult_ab", {ma, mb}, 64'd0);
    check("rstw_prod", rprod, 64'd0);
    check("rstw_id", 64'(rid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rv | busy | start) quiet++;
    end
    check("rstw_no_resp", 64'(quiet), 64'd0);
    run_op('{1'b1, 32'd11, 32'd13, 64'd143});

    // MULT_CYCLES=1 instance: all-ones operands, latency 3.
    @(negedge clk);
    d1_v0 = 1'b1; d1_a0 = 32'hFFFF_FFFF; d1_b0 = 32'hFFFF_FFFF; d1_rr = 1'b1;
    #1;
    check("mc1_ready", 64'(d1_r0), 64'd1);
    @(negedge clk);
    d1_v0 = 1'b0;
    check("mc1_start", 64'(d1_start), 64'd1);
    lat = 1; got = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (d1_rv) got = 1;
    end
    check("mc1_latency", 64'(lat), 64'd3);
    check("mc1_prod", d1_rprod, 64'hFFFF_FFFE_0000_0001);
    check("mc1_id", 64'(d1_rid), 64'd0);
    @(negedge clk);
    check("mc1_idle", {62'd0, d1_rv, d1_busy}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
